uart_tx_param: RTL



---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_tx_param_if.sv | 22 ++
 rtl/uart_baud_gen.sv | 42 ++++
 rtl/uart_tx_param.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the parametrised UART blocks (transmitter now, the
// receiver later): parity mode encodings, transmitter state encoding and a
// constant function that sizes the baud down-counter.
// -----------------------------------------------------------------------------
package uart_pkg;

    // Parity mode encodings used by the PARITY parameter.
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Transmitter frame states, in line order.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    // Counter width able to hold 0 .. n-1, i.e. clog2(n), never less than 1.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// -----------------------------------------------------------------------------
// uart_tx_param_if
// Character-request / serial-line bundle of the parametrised UART transmitter.
//   START  request to send DATA (level, sampled when BUSY = 0)
//   DATA   character, captured in the accepting cycle
//   TXD    serial line, idle high
//   BUSY   frame in progress
//   DONE   one-cycle pulse when the last stop bit completes
// master: the character source; slave: the transmitter.
// -----------------------------------------------------------------------------
interface uart_tx_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 START;
    logic [DATA_BITS-1:0] DATA;
    logic                 TXD;
    logic                 BUSY;
    logic                 DONE;

    modport master (output START, output DATA, input TXD, input BUSY, input DONE);
    modport slave  (input START, input DATA, output TXD, output BUSY, output DONE);
endinterface

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Bit-period timer shared by the UART transmitter and receiver. A down-counter
// that reloads every CLKS_PER_BIT cycles and flags the last cycle of each bit.
//   clk      system clock, rising edge
//   rst_n    synchronous active-low reset (counter cleared)
//   restart  reload the counter so a new bit period starts next cycle
//   tick     high in the last cycle of every bit period
// -----------------------------------------------------------------------------
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int         CNT_W  = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    // NOTE: sequential state is assigned with <= only, so every register in
    // this block sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (restart || cnt_q == '0) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Restart loads CLKS_PER_BIT-1, so the tick lands exactly CLKS_PER_BIT
    // cycles after the restart edge: no phase jitter relative to START.
    assign tick = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_param.sv
// -----------------------------------------------------------------------------
// uart_tx_param
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional odd/even parity, STOP_BITS stop bits. Each bit lasts
// CLK_FREQ/BAUD clock cycles. A request arriving in the DONE cycle starts the
// next frame right away.
//   CLK    system clock, rising edge
//   RST_N  synchronous active-low reset; aborts a frame in progress
//   bus    uart_tx_param_if slave: START, DATA in; TXD, BUSY, DONE out
// -----------------------------------------------------------------------------
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 48_000_000,
    parameter int BAUD      = 38_400,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = PAR_NONE,
    parameter int STOP_BITS = 1
) (
    input  logic            CLK,
    input  logic            RST_N,
    uart_tx_param_if.slave  bus
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx_param: CLK_FREQ/BAUD must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
        $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
        $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end

    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    tx_state_t            state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic                 txd_q, txd_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 restart;
    logic                 tick;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk     (CLK),
        .rst_n   (RST_N),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // NOTE: the shift register and parity bit carry no reset; both are loaded
    // on every accept before anything reads them.
    always_ff @(posedge CLK) begin
        shreg_q <= shreg_d;
        par_q   <= par_d;
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        par_d     = par_q;
        bit_cnt_d = bit_cnt_q;
        txd_d     = txd_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        restart   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                txd_d  = 1'b1;
                busy_d = 1'b0;
                if (bus.START) begin
                    state_d   = ST_START;
                    shreg_d   = bus.DATA;
                    // Even: parity = XOR of data; odd: its complement.
                    par_d     = (PARITY == PAR_ODD) ? ~(^bus.DATA) : ^bus.DATA;
                    bit_cnt_d = '0;
                    txd_d     = 1'b0;
                    busy_d    = 1'b1;
                    restart   = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d   = ST_DATA;
                    txd_d     = shreg_q[0];
                    shreg_d   = shreg_q >> 1;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        if (PARITY != PAR_NONE) begin
                            state_d = ST_PARITY;
                            txd_d   = par_q;
                        end else begin
                            state_d = ST_STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        txd_d     = shreg_q[0];
                        shreg_d   = shreg_q >> 1;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_d   = ST_STOP;
                    txd_d     = 1'b1;
                    bit_cnt_d = '0;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        // TXD stays high through the DONE cycle; a START seen
                        // there is accepted from IDLE on the following edge.
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.TXD  = txd_q;
    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;

endmodule
